// File: rtl/lockout_ctrl_pkg.sv
// Shared definitions for the lock project: state encodings, parameter defaults
// and the attempt record handed from the comparator to the lockout FSM.
package lockout_ctrl_pkg;

  localparam int DEF_MAX_FAIL  = 3;
  localparam int DEF_LOCK_SECS = 30;
  localparam int DEF_OPEN_SECS = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_BAD     = 2'd3
  } lock_state_e;

  typedef struct packed {
    logic valid;
    logic pass;
  } att_t;

  // {entry_en, unlocked, alarm} for a given state
  function automatic logic [2:0] state_flags(lock_state_e s);
    case (s)
      ST_IDLE:    return 3'b100;
      ST_OPEN:    return 3'b010;
      ST_LOCKOUT: return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable 8-bit down-counter stepped by the one-second tick; done flags the
// tick that takes the count from 1 to 0 so the FSM can leave in the same clk.
module sec_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic [7:0] cnt,
  output logic       done
);

  always_ff @(posedge clk) begin
    if (!rst)                        cnt <= 8'd0;
    else if (clr)                    cnt <= 8'd0;
    else if (load)                   cnt <= load_val;
    else if (tick && cnt != 8'd0)    cnt <= cnt - 8'd1;
  end

  assign done = tick && (cnt == 8'd1);

endmodule

// File: rtl/lockout_ctrl.sv
// Keypad lockout FSM: counts consecutive failed attempts, holds the door open
// after a pass and enforces a timed lockout after MAX_FAIL failures.
module lockout_ctrl
  import lockout_ctrl_pkg::*;
#(
  parameter int MAX_FAIL  = DEF_MAX_FAIL,
  parameter int LOCK_SECS = DEF_LOCK_SECS,
  parameter int OPEN_SECS = DEF_OPEN_SECS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       att_valid,
  input  logic       att_pass,
  input  logic       clear,
  output logic       entry_en,
  output logic       unlocked,
  output logic       alarm,
  output logic [3:0] fail_cnt,
  output logic [7:0] remaining,
  output logic [1:0] state
);

  localparam logic [4:0] MAX_FAIL_V  = 5'(MAX_FAIL);
  localparam logic [3:0] MAX_FAIL_4  = 4'(MAX_FAIL);
  localparam logic [7:0] LOCK_SECS_V = 8'(LOCK_SECS);
  localparam logic [7:0] OPEN_SECS_V = 8'(OPEN_SECS);

  lock_state_e state_q, state_nxt;
  logic [3:0]  fail_q, fail_nxt;
  logic [2:0]  flags_q;
  logic        t_load, t_clr, t_done;
  logic [7:0]  t_load_val;
  att_t        att;

  assign att = '{valid: att_valid, pass: att_pass};

  sec_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (t_load_val),
    .tick     (tick),
    .cnt      (remaining),
    .done     (t_done)
  );

  // Priority: clear, then timer expiry, then attempts (only seen in IDLE).
  always_comb begin
    state_nxt  = state_q;
    fail_nxt   = fail_q;
    t_load     = 1'b0;
    t_load_val = 8'd0;
    if (clear) begin
      state_nxt = ST_IDLE;
      fail_nxt  = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (att.valid) begin
            if (att.pass) begin
              state_nxt  = ST_OPEN;
              fail_nxt   = 4'd0;
              t_load     = 1'b1;
              t_load_val = OPEN_SECS_V;
            end else if (({1'b0, fail_q} + 5'd1) >= MAX_FAIL_V) begin
              state_nxt  = ST_LOCKOUT;
              fail_nxt   = MAX_FAIL_4;
              t_load     = 1'b1;
              t_load_val = LOCK_SECS_V;
            end else begin
              fail_nxt = fail_q + 4'd1;
            end
          end
        end
        ST_OPEN: begin
          if (t_done) state_nxt = ST_IDLE;
        end
        ST_LOCKOUT: begin
          if (t_done) begin
            state_nxt = ST_IDLE;
            fail_nxt  = 4'd0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          fail_nxt  = 4'd0;
        end
      endcase
    end
  end

  // Anything landing in IDLE without a fresh load parks the timer at zero.
  assign t_clr = (state_nxt == ST_IDLE) && !t_load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fail_q  <= 4'd0;
      flags_q <= state_flags(ST_IDLE);
    end else begin
      state_q <= state_nxt;
      fail_q  <= fail_nxt;
      flags_q <= state_flags(state_nxt);
    end
  end

  assign entry_en = flags_q[2];
  assign unlocked = flags_q[1];
  assign alarm    = flags_q[0];
  assign fail_cnt = fail_q;
  assign state    = state_q;

endmodule

// File: tb/tb_lockout_ctrl.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a rule-level reference model of the lockout behaviour.
module tb_lockout_ctrl;

  localparam int MAXF = 3;
  localparam int LOCK = 30;
  localparam int OPNS = 5;

  logic       clk = 1'b0;
  logic       rst, tick, att_valid, att_pass, clear;
  logic       entry_en, unlocked, alarm;
  logic [3:0] fail_cnt;
  logic [7:0] remaining;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 open, 2 lockout
  int m_st, m_fc, m_rem;

  always #5 clk = ~clk;

  lockout_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .att_valid (att_valid),
    .att_pass  (att_pass),
    .clear     (clear),
    .entry_en  (entry_en),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt),
    .remaining (remaining),
    .state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit av, input bit ap, input bit c);
    if (!r || c) begin
      m_st = 0; m_fc = 0; m_rem = 0;
    end else if (m_st != 0) begin
      if (t && m_rem == 1) begin
        if (m_st == 2) m_fc = 0;
        m_st = 0; m_rem = 0;
      end else if (t && m_rem > 1) begin
        m_rem = m_rem - 1;
      end
    end else if (av) begin
      if (ap) begin
        m_st = 1; m_fc = 0; m_rem = OPNS;
      end else if (m_fc + 1 >= MAXF) begin
        m_st = 2; m_fc = MAXF; m_rem = LOCK;
      end else begin
        m_fc = m_fc + 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".state"},     32'(state),     32'(m_st));
    chk({tag, ".fail_cnt"},  32'(fail_cnt),  32'(m_fc));
    chk({tag, ".remaining"}, 32'(remaining), 32'(m_rem));
    chk({tag, ".entry_en"},  32'(entry_en),  32'(m_st == 0));
    chk({tag, ".unlocked"},  32'(unlocked),  32'(m_st == 1));
    chk({tag, ".alarm"},     32'(alarm),     32'(m_st == 2));
  endtask

  // one clk: apply inputs, clock, sample 1 time unit after the edge
  task automatic cyc(input string tag, input bit r, input bit t, input bit av,
                     input bit ap, input bit c);
    rst = r; tick = t; att_valid = av; att_pass = ap; clear = c;
    model_step(r, t, av, ap, c);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; att_valid = 1'b0; att_pass = 1'b0; clear = 1'b0;
    m_st = 0; m_fc = 0; m_rem = 0;

    // reset, with inputs active that must be ignored
    cyc("rst0", 0, 1, 1, 1, 0);
    cyc("rst1", 0, 0, 1, 0, 1);
    chk("rst.entry_en", 32'(entry_en), 1);
    chk("rst.state", 32'(state), 0);

    // three fails -> lockout
    cyc("f1", 1, 0, 1, 0, 0); chk("f1.cnt", 32'(fail_cnt), 1);
    cyc("f2", 1, 0, 1, 0, 0); chk("f2.cnt", 32'(fail_cnt), 2);
    cyc("f3", 1, 0, 1, 0, 0);
    chk("f3.cnt", 32'(fail_cnt), 3);
    chk("f3.state", 32'(state), 2);
    chk("f3.alarm", 32'(alarm), 1);
    chk("f3.rem", 32'(remaining), 30);
    chk("f3.entry", 32'(entry_en), 0);

    // lockout countdown with an ignored pass and idle gaps
    for (int i = 1; i <= LOCK; i++) begin
      if (i % 7 == 0) cyc("lk.gap", 1, 0, 1, 0, 0);
      cyc("lk", 1, 1, (i == 10), 1, 0);
      if (i < LOCK) chk("lk.rem", 32'(remaining), 32'(LOCK - i));
    end
    chk("lk.end.state", 32'(state), 0);
    chk("lk.end.cnt", 32'(fail_cnt), 0);
    chk("lk.end.alarm", 32'(alarm), 0);

    // tick in idle does nothing
    cyc("idle.tick", 1, 1, 0, 0, 0);

    // two fails then pass -> open, then expire
    cyc("o.f1", 1, 0, 1, 0, 0);
    cyc("o.f2", 1, 0, 1, 0, 0);
    cyc("o.p", 1, 0, 1, 1, 0);
    chk("o.unlocked", 32'(unlocked), 1);
    chk("o.cnt", 32'(fail_cnt), 0);
    chk("o.rem", 32'(remaining), 5);
    for (int i = 0; i < OPNS; i++) cyc("o.t", 1, 1, 0, 0, 0);
    chk("o.end.state", 32'(state), 0);

    // clear beats a fail during lockout
    cyc("c.f1", 1, 0, 1, 0, 0);
    cyc("c.f2", 1, 0, 1, 0, 0);
    cyc("c.f3", 1, 0, 1, 0, 0);
    cyc("c.t", 1, 1, 0, 0, 0);
    cyc("c.clr", 1, 0, 1, 0, 1);
    chk("c.state", 32'(state), 0);
    chk("c.cnt", 32'(fail_cnt), 0);
    chk("c.rem", 32'(remaining), 0);

    // reset mid-open
    cyc("r.p", 1, 0, 1, 1, 0);
    cyc("r.t1", 1, 1, 0, 0, 0);
    cyc("r.t2", 1, 1, 0, 0, 0);
    chk("r.rem3", 32'(remaining), 3);
    cyc("r.rst", 0, 0, 0, 0, 0);
    chk("r.state", 32'(state), 0);
    chk("r.rem", 32'(remaining), 0);
    chk("r.entry", 32'(entry_en), 1);

    // tick and pass together in idle: fresh timer is not decremented
    cyc("tp", 1, 1, 1, 1, 0);
    chk("tp.state", 32'(state), 1);
    chk("tp.rem", 32'(remaining), 5);
    cyc("tp.clr", 1, 0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, t, av, ap, c;
      r  = ($urandom_range(0, 199) != 0);
      t  = ($urandom_range(0, 9) < 4);
      av = ($urandom_range(0, 9) < 3);
      ap = ($urandom_range(0, 9) < 3);
      c  = ($urandom_range(0, 99) == 0);
      cyc("rnd", r, t, av, ap, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
